// File: rtl/cmul_pkg.sv
// cmul_pkg: shared widths, types and helpers for the cmul_pipe complex multiplier.
package cmul_pkg;

   localparam int unsigned CMUL_W_DEF  = 8;
   localparam int unsigned CMUL_W_MIN  = 4;
   localparam int unsigned CMUL_W_MAX  = 18;
   // Holds rr - ii / ri + ir without loss at the largest legal W.
   localparam int unsigned CMUL_CPLX_W = 2*CMUL_W_MAX+3;
   // Working width of the round/saturate datapath.
   localparam int unsigned CMUL_ACC_W  = 64;

   typedef struct packed {
      logic signed [CMUL_CPLX_W-1:0] re;
      logic signed [CMUL_CPLX_W-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic                         sat;
      logic signed [CMUL_ACC_W-1:0] val;
   } satres_t;

   // Output components must hold the full product without overflow.
   function automatic logic ow_ok(input int unsigned w, input int unsigned ow);
      return ow >= 2*w+1;
   endfunction

   // Arithmetic right shift with round-half-up, then clip to signed w bits.
   function automatic satres_t sat_round(input logic signed [CMUL_ACC_W-1:0] value,
                                         input int unsigned shift,
                                         input int unsigned w);
      logic signed [CMUL_ACC_W-1:0] one;
      logic signed [CMUL_ACC_W-1:0] r;
      logic signed [CMUL_ACC_W-1:0] hi;
      logic signed [CMUL_ACC_W-1:0] lo;
      satres_t                      res;
      one = 64'sd1;
      r   = value;
      if (shift > 0) begin
         r = (value + (one <<< (shift-1))) >>> shift;
      end
      hi      = (one <<< (w-1)) - one;
      lo      = -hi - one;
      res.sat = 1'b0;
      res.val = r;
      if (r > hi) begin
         res.val = hi;
         res.sat = 1'b1;
      end else if (r < lo) begin
         res.val = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/cmul_pipe_mult.sv
// cmul_mult: registered signed AW x AW multiplier with load enable.
module cmul_mult
   import cmul_pkg::*;
#(
   parameter int unsigned AW = CMUL_W_DEF+1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic signed [AW-1:0]   a,
   input  logic signed [AW-1:0]   b,
   output logic signed [2*AW-1:0] p
);

   logic signed [2*AW-1:0] ax;
   logic signed [2*AW-1:0] bx;

   assign ax = (2*AW)'(a);
   assign bx = (2*AW)'(b);

   // Product register, loads only when the pipeline advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p <= '0;
      end else if (en) begin
         p <= ax * bx;
      end
   end

endmodule

// File: rtl/cmul_pipe.sv
// cmul_pipe: 3-stage pipelined signed complex multiplier, p = a*b or a*conj(b),
// valid/ready on both sides. Optional CMUL_SAT_EN: shift/round/saturate to W
// bits in S3 and expose the sat flag port.
module cmul_pipe
   import cmul_pkg::*;
#(
   parameter int unsigned W     = CMUL_W_DEF,
   parameter int unsigned OW    = 2*W+1,
   parameter int unsigned SHIFT = W-1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 conj,
   input  logic signed [W-1:0]  a_re,
   input  logic signed [W-1:0]  a_im,
   input  logic signed [W-1:0]  b_re,
   input  logic signed [W-1:0]  b_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] p_re,
   output logic signed [OW-1:0] p_im
`ifdef CMUL_SAT_EN
   ,
   output logic                 sat
`endif
);

   localparam int unsigned PW = 2*W+2;

   if (W < CMUL_W_MIN || W > CMUL_W_MAX) begin : g_bad_w
      $error("cmul_pipe: W out of range 4..18");
   end
   if (!ow_ok(W, OW)) begin : g_bad_ow
      $error("cmul_pipe: OW must be at least 2*W+1");
   end
   if (SHIFT >= CMUL_ACC_W-1) begin : g_bad_shift
      $error("cmul_pipe: SHIFT exceeds rounding datapath width");
   end

   logic advance;
   logic v1, v2, v3;

   logic signed [W:0] s1_are, s1_aim, s1_bre, s1_bim;
   logic signed [PW-1:0] rr, ii, ri, ir;
   cplx_t full;

   // The whole pipeline moves together unless the output beat is blocked.
   assign advance   = ~v3 | out_ready;
   assign in_ready  = advance;
   assign out_valid = v3;

   // S1: operand capture; conj negates b_im at W+1 bits so the most negative value is exact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1     <= 1'b0;
         s1_are <= '0;
         s1_aim <= '0;
         s1_bre <= '0;
         s1_bim <= '0;
      end else if (advance) begin
         v1     <= in_valid;
         s1_are <= (W+1)'(a_re);
         s1_aim <= (W+1)'(a_im);
         s1_bre <= (W+1)'(b_re);
         s1_bim <= conj ? -((W+1)'(b_im)) : (W+1)'(b_im);
      end
   end

   // S2: valid bit travelling alongside the product registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2 <= 1'b0;
      end else if (advance) begin
         v2 <= v1;
      end
   end

   cmul_mult #(.AW(W+1)) u_rr (.clk(clk), .rst(rst), .en(advance), .a(s1_are), .b(s1_bre), .p(rr));
   cmul_mult #(.AW(W+1)) u_ii (.clk(clk), .rst(rst), .en(advance), .a(s1_aim), .b(s1_bim), .p(ii));
   cmul_mult #(.AW(W+1)) u_ri (.clk(clk), .rst(rst), .en(advance), .a(s1_are), .b(s1_bim), .p(ri));
   cmul_mult #(.AW(W+1)) u_ir (.clk(clk), .rst(rst), .en(advance), .a(s1_aim), .b(s1_bre), .p(ir));

   // Full-precision combine of the S2 products.
   always_comb begin
      full.re = CMUL_CPLX_W'(rr) - CMUL_CPLX_W'(ii);
      full.im = CMUL_CPLX_W'(ri) + CMUL_CPLX_W'(ir);
   end

`ifdef CMUL_SAT_EN
   satres_t sr_re, sr_im;

   // Rounding and clipping fold into the S3 cycle, so latency is unchanged.
   always_comb begin
      sr_re = sat_round(CMUL_ACC_W'(full.re), SHIFT, W);
      sr_im = sat_round(CMUL_ACC_W'(full.im), SHIFT, W);
   end

   // S3: scaled, saturated result and clip flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3   <= 1'b0;
         p_re <= '0;
         p_im <= '0;
         sat  <= 1'b0;
      end else if (advance) begin
         v3   <= v2;
         p_re <= OW'(sr_re.val);
         p_im <= OW'(sr_im.val);
         sat  <= sr_re.sat | sr_im.sat;
      end
   end
`else
   // S3: full-precision result; narrowing to OW is lossless since |p| <= 2^(2W-1).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3   <= 1'b0;
         p_re <= '0;
         p_im <= '0;
      end else if (advance) begin
         v3   <= v2;
         p_re <= OW'(full.re);
         p_im <= OW'(full.im);
      end
   end
`endif

endmodule

// File: tb/tb_cmul_pipe.sv
// tb_cmul_pipe: self-checking bench for cmul_pipe (W=8), fixed vectors plus
// randomized streams against a complex-arithmetic reference model.
module tb_cmul_pipe;

   localparam int unsigned W     = 8;
   localparam int unsigned OW    = 2*W+1;
   localparam int unsigned SHIFT = W-1;

   typedef struct {
      logic                conj;
      logic signed [W-1:0] ar;
      logic signed [W-1:0] ai;
      logic signed [W-1:0] br;
      logic signed [W-1:0] bi;
   } beat_t;

   typedef struct {
      longint re;
      longint im;
      logic   sat;
   } exp_t;

   typedef struct {
      beat_t b;
      exp_t  e;
   } vec_t;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic                 conj;
   logic signed [W-1:0]  a_re, a_im, b_re, b_im;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] p_re, p_im;
`ifdef CMUL_SAT_EN
   logic                 sat;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sbq[$];
   vec_t vt[8];

   cmul_pipe #(.W(W), .OW(OW), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .conj(conj),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .p_re(p_re), .p_im(p_im)
`ifdef CMUL_SAT_EN
      , .sat(sat)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference: textbook complex product, then the optional scale/round/clip rule.
   function automatic exp_t model(input beat_t b);
      longint ar, ai, br, bi, re, im, lim;
      exp_t e;
      ar = b.ar; ai = b.ai; br = b.br; bi = b.bi;
      if (b.conj) begin
         re = ar*br + ai*bi;
         im = ai*br - ar*bi;
      end else begin
         re = ar*br - ai*bi;
         im = ar*bi + ai*br;
      end
      e.sat = 1'b0;
`ifdef CMUL_SAT_EN
      lim = longint'(1) <<< (W-1);
      re = (re + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
      im = (im + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
      if (re > lim-1) begin re = lim-1; e.sat = 1'b1; end
      if (re < -lim)  begin re = -lim;  e.sat = 1'b1; end
      if (im > lim-1) begin im = lim-1; e.sat = 1'b1; end
      if (im < -lim)  begin im = -lim;  e.sat = 1'b1; end
`else
      lim = 0;
`endif
      e.re = re;
      e.im = im;
      return e;
   endfunction

   function automatic logic signed [W-1:0] rcomp();
      logic signed [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = {1'b1, {(W-1){1'b0}}};
         1:       v = {1'b0, {(W-1){1'b1}}};
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   function automatic beat_t rbeat();
      beat_t b;
      b.conj = 1'($urandom_range(0, 1));
      b.ar = rcomp(); b.ai = rcomp(); b.br = rcomp(); b.bi = rcomp();
      return b;
   endfunction

   function automatic vec_t mkv(input int c, input int ar, input int ai, input int br,
                                input int bi, input longint er, input longint ei, input int es);
      vec_t v;
      v.b.conj = 1'(c);
      v.b.ar = W'(ar); v.b.ai = W'(ai); v.b.br = W'(br); v.b.bi = W'(bi);
      v.e.re = er; v.e.im = ei; v.e.sat = 1'(es);
      return v;
   endfunction

   task automatic drive(input beat_t b, input logic v);
      in_valid = v;
      conj = b.conj;
      a_re = b.ar; a_im = b.ai; b_re = b.br; b_im = b.bi;
   endtask

   task automatic check_out(input string nm, input exp_t e);
      chk({nm, "_re"}, p_re, e.re);
      chk({nm, "_im"}, p_im, e.im);
`ifdef CMUL_SAT_EN
      chk({nm, "_sat"}, sat, e.sat);
`endif
   endtask

   // One isolated beat: checks acceptance, 3-cycle latency and the result.
   task automatic single(input string nm, input beat_t b, input exp_t e);
      int lat;
      beat_t idle;
      idle = b;
      lat = 0;
      @(negedge clk);
      drive(b, 1'b1);
      out_ready = 1'b1;
      #1;
      chk({nm, "_in_ready"}, in_ready, 1);
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         @(negedge clk);
         drive(idle, 1'b0);
         #1;
         if (out_valid) lat = i;
      end
      chk({nm, "_latency"}, lat, 3);
      if (lat != 0) check_out(nm, e);
      @(negedge clk);
      #1;
      chk({nm, "_no_dup"}, out_valid, 0);
   endtask

   // mode 0: free flow, 1: 5-cycle stall at first output, 2: random valid/ready.
   task automatic stream(input string nm, input int nb, input int mode);
      int sent, got, bp_left, extra;
      bit first_seen, held;
      logic signed [OW-1:0] hre, him;
      beat_t cur;
      exp_t e;
      sent = 0; got = 0; bp_left = 5; extra = 0;
      first_seen = 0; held = 0; hre = '0; him = '0;
      cur = rbeat();
      for (int cyc = 0; cyc < 4000 && got < nb; cyc++) begin
         @(negedge clk);
         drive(cur, (sent < nb) && (mode != 2 || $urandom_range(0, 3) != 0));
         out_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (mode == 1) begin
            if (out_valid) first_seen = 1;
            if (first_seen && bp_left > 0) begin
               out_ready = 1'b0;
               bp_left--;
            end
         end
         #1;
         if (held) begin
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_re"}, p_re, hre);
            chk({nm, "_hold_im"}, p_im, him);
         end
         held = 0;
         if (out_valid && !out_ready) begin
            chk({nm, "_stall_in_ready"}, in_ready, 0);
            held = 1; hre = p_re; him = p_im;
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk({nm, "_spurious_out"}, 1, 0);
            end else begin
               e = sbq.pop_front();
               check_out(nm, e);
               got++;
            end
         end
         if (in_valid && in_ready) begin
            sbq.push_back(model(cur));
            sent++;
            cur = rbeat();
         end
      end
      chk({nm, "_received"}, got, nb);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (out_valid) extra++;
         @(negedge clk);
      end
      chk({nm, "_no_extra"}, extra, 0);
      chk({nm, "_queue_empty"}, sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      int stale;
      beat_t b;
      exp_t e;

`ifdef CMUL_SAT_EN
      vt[0] = mkv(0,    3,    4,    1,    2,    0,    0, 0);
      vt[1] = mkv(0, -128, -128, -128, -128,    0,  127, 1);
      vt[2] = mkv(1, -128, -128, -128, -128,  127,    0, 1);
      vt[3] = mkv(0,   64,    0,    2,    0,    1,    0, 0);
      vt[4] = mkv(0, -128,    0,  127,    0, -127,    0, 0);
      vt[5] = mkv(0, -128,  127,  127,  127, -128,   -1, 1);
      vt[6] = mkv(1,    1,    1,    0,    1,    0,    0, 0);
      vt[7] = mkv(1, -128,    0,    0, -128,    0, -128, 0);
`else
      vt[0] = mkv(0,    3,    4,    1,    2,     -5,     10, 0);
      vt[1] = mkv(0, -128, -128, -128, -128,      0,  32768, 0);
      vt[2] = mkv(1, -128, -128, -128, -128,  32768,      0, 0);
      vt[3] = mkv(1,    1,    1,    0,    1,      1,     -1, 0);
      vt[4] = mkv(0,  127,  127, -128,    0, -16256, -16256, 0);
      vt[5] = mkv(0, -128,  127,  127,  127, -32385,   -127, 0);
      vt[6] = mkv(0,    0,    0,  -77,   99,      0,      0, 0);
      vt[7] = mkv(1, -128,    0,    0, -128,      0, -16384, 0);
`endif

      rst = 1'b1;
      out_ready = 1'b1;
      drive(vt[0].b, 1'b0);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_p_re", p_re, 0);
      chk("reset_p_im", p_im, 0);
`ifdef CMUL_SAT_EN
      chk("reset_sat", sat, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         single($sformatf("vec%0d", i), vt[i].b, vt[i].e);
      end

      stream("backpressure", 6, 1);

      // Reset with three beats in flight.
      @(negedge clk);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(rbeat(), 1'b1);
         @(negedge clk);
      end
      drive(vt[0].b, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_p_re", p_re, 0);
      chk("midrst_p_im", p_im, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (out_valid) stale++;
         @(negedge clk);
      end
      chk("midrst_no_stale", stale, 0);
      b = vt[0].b;
      e = model(b);
      single("after_rst", b, e);

      stream("random", 300, 2);
      stream("freeflow", 20, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
